// File: rtl/regex_pkg.sv
// Shared constants and the per-position hit predicate for the window matcher.
package regex_pkg;
  localparam int MAX_DEPTH = 64;

  // Wildcard positions always hit; cared positions hit only on an equal character.
  function automatic logic hit(input logic care, input logic val, input logic c);
    return !care | (val == c);
  endfunction
endpackage

// File: rtl/regex_pos_cell.sv
// One pattern position: holds "positions 0..k matched" and computes its next value.
module regex_pos_cell
  import regex_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_flush,
  input  logic i_adv,
  input  logic i_prev,
  input  logic i_care,
  input  logic i_val,
  input  logic i_c,
  output logic o_s,
  output logic o_nxt
);
  logic r_s;

  assign o_nxt = i_prev & hit(i_care, i_val, i_c);
  assign o_s   = r_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_s <= 1'b0;
    else if (i_flush) r_s <= 1'b0;
    else if (i_adv)   r_s <= o_nxt;
  end
endmodule

// File: rtl/regex_window_matcher.sv
// Streaming matcher for a fixed-length binary pattern with per-position wildcards.
module regex_window_matcher
  import regex_pkg::*;
#(
  parameter int               DEPTH      = 21,
  parameter int               CNT_W      = 16,
  parameter logic [DEPTH-1:0] RST_CARE   = DEPTH'(1),
  parameter logic [DEPTH-1:0] RST_VAL    = DEPTH'(1),
  parameter logic             RST_ANCHOR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [DEPTH-1:0] cfg_care,
  input  logic [DEPTH-1:0] cfg_val,
  input  logic             cfg_anchor,
  input  logic             clear,
  input  logic             i_c_valid,
  input  logic             i_c,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] last_match_pos
);
  logic [DEPTH-1:0] r_care, r_val;
  logic             r_anchor;
  logic [CNT_W-1:0] r_pos, r_cnt, r_last;
  logic             r_match;

  logic [DEPTH-1:0] w_s, w_nxt;
  logic             w_flush, w_adv, w_start, w_done;

  // Config writes and clears both restart the stream and swallow any concurrent character.
  assign w_flush = cfg_we | clear;
  assign w_adv   = i_c_valid & ~w_flush;
  assign w_start = ~r_anchor | (r_pos == '0);
  assign w_done  = w_adv & w_nxt[DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_cell
    logic w_prev;
    if (k == 0) begin : g_first
      assign w_prev = w_start;
    end else begin : g_chain
      assign w_prev = w_s[k-1];
    end

    regex_pos_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .i_flush (w_flush),
      .i_adv   (w_adv),
      .i_prev  (w_prev),
      .i_care  (r_care[k]),
      .i_val   (r_val[k]),
      .i_c     (i_c),
      .o_s     (w_s[k]),
      .o_nxt   (w_nxt[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_care   <= RST_CARE;
      r_val    <= RST_VAL;
      r_anchor <= RST_ANCHOR;
    end else if (cfg_we) begin
      r_care   <= cfg_care;
      r_val    <= cfg_val;
      r_anchor <= cfg_anchor;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos   <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_match <= 1'b0;
    end else if (w_flush) begin
      r_pos   <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_done;
      // A saturated position never reads as zero, so an anchored stream cannot restart.
      if (w_adv && r_pos != '1) r_pos <= r_pos + CNT_W'(1);
      if (w_done) begin
        r_last <= r_pos;
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign match          = r_match;
  assign match_cnt      = r_cnt;
  assign last_match_pos = r_last;
endmodule
